// File: rtl/onchip_stream_writer_if.sv
// Stream and on-chip RAM bus bundle for onchip_stream_writer.
// master: the writer (stream sink, Avalon-MM RAM master).
// slave:  the environment (stream source plus RAM).
interface onchip_stream_writer_if #(
  parameter int ADDR_W = 16
);
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata;
  logic              mem_clken;

  modport master (
    input  s_valid, s_data, mem_readdata,
    output s_ready, mem_address, mem_byteenable, mem_chipselect,
           mem_write, mem_writedata, mem_clken
  );

  modport slave (
    output s_valid, s_data, mem_readdata,
    input  s_ready, mem_address, mem_byteenable, mem_chipselect,
           mem_write, mem_writedata, mem_clken
  );
endinterface

// File: rtl/onchip_stream_writer.sv
// onchip_stream_writer: packs an 8-bit valid/ready byte stream little-endian
// into 32-bit words and writes them to consecutive on-chip RAM words from a
// programmable base, with partial-word flush and wrap at the end of memory.
// Optional readback verify of every written word: define ONCHIP_WRITER_VERIFY_EN.
module onchip_stream_writer #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 40960
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic                  flush,
  onchip_stream_writer_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  wrapped,
  output logic [15:0]           words_written,
  output logic [7:0]            err_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [31:0]       DEPTH_U   = 32'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WRITE,
`ifdef ONCHIP_WRITER_VERIFY_EN
    VREAD,
    VCMP,
`endif
    DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] ptr;
  logic [1:0]        lane;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              flush_pending;
  logic              accept;
  logic [2:0]        lane_after;
  logic              advance;

  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign bus.mem_clken = 1'b1;

  // Next-state, stream handshake and RAM bus strobes decoded from the current state
  always_comb begin
    state_next         = state;
    bus.s_ready        = 1'b0;
    bus.mem_chipselect = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_address    = '0;
    bus.mem_byteenable = 4'h0;
    bus.mem_writedata  = 32'h0;
    advance            = 1'b0;
    accept             = (state == FILL) && bus.s_valid;
    lane_after         = {1'b0, lane} + {2'b00, accept};
    case (state)
      IDLE: begin
        if (start) state_next = FILL;
      end
      FILL: begin
        bus.s_ready = 1'b1;
        if (lane_after == 3'd4) state_next = WRITE;
        else if (flush)         state_next = (lane_after != 3'd0) ? WRITE : DONE;
      end
      WRITE: begin
        bus.mem_chipselect = 1'b1;
        bus.mem_write      = 1'b1;
        bus.mem_address    = ptr;
        bus.mem_byteenable = be;
        bus.mem_writedata  = wdata;
`ifdef ONCHIP_WRITER_VERIFY_EN
        state_next = VREAD;
`else
        advance    = 1'b1;
        state_next = (flush_pending || flush) ? DONE : FILL;
`endif
      end
`ifdef ONCHIP_WRITER_VERIFY_EN
      VREAD: begin
        bus.mem_chipselect = 1'b1;
        bus.mem_address    = ptr;
        bus.mem_byteenable = 4'hF;
        state_next         = VCMP;
      end
      VCMP: begin
        advance    = 1'b1;
        state_next = (flush_pending || flush) ? DONE : FILL;
      end
`endif
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

`ifdef ONCHIP_WRITER_VERIFY_EN
  logic [31:0] lane_mask;
  logic        mismatch;

  // Readback compare restricted to the byte lanes that were actually written
  always_comb begin
    lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    mismatch  = |((bus.mem_readdata ^ wdata) & lane_mask);
  end

  // Saturating count of readback mismatches, cleared when a session starts
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= 8'h00;
    end else if (state == IDLE && start) begin
      err_count <= 8'h00;
    end else if (state == VCMP && mismatch && err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end
`else
  assign err_count = 8'h00;
`endif

  // Byte packing, flush latching, pointer advance/wrap and word counting
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr           <= '0;
      lane          <= 2'd0;
      be            <= 4'h0;
      wdata         <= 32'h0;
      flush_pending <= 1'b0;
      wrapped       <= 1'b0;
      words_written <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ptr           <= (32'(base_addr) >= DEPTH_U) ? '0 : base_addr;
            lane          <= 2'd0;
            be            <= 4'h0;
            wdata         <= 32'h0;
            flush_pending <= 1'b0;
            wrapped       <= 1'b0;
            words_written <= 16'h0000;
          end
        end
        FILL: begin
          if (accept) begin
            wdata[{lane, 3'b000} +: 8] <= bus.s_data;
            be[lane]                   <= 1'b1;
            lane                       <= lane + 2'd1;
          end
          if (flush) flush_pending <= 1'b1;
        end
        DONE: begin
          flush_pending <= 1'b0;
        end
        default: begin
          if (flush) flush_pending <= 1'b1;
        end
      endcase
      if (advance) begin
        if (ptr == LAST_ADDR) begin
          ptr     <= '0;
          wrapped <= 1'b1;
        end else begin
          ptr <= ptr + 1'b1;
        end
        if (words_written != 16'hFFFF) words_written <= words_written + 16'd1;
        lane  <= 2'd0;
        be    <= 4'h0;
        wdata <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_onchip_stream_writer.sv
// Testbench for onchip_stream_writer: scoreboard of expected RAM writes fed
// by a small packing model, plus a RAM model that supports readback.
module tb_onchip_stream_writer;

  localparam int ADDR_W = 16;
  localparam int DEPTH  = 40960;
`ifdef ONCHIP_WRITER_VERIFY_EN
  localparam int CYCLES_PER_WORD = 7;
`else
  localparam int CYCLES_PER_WORD = 5;
`endif

  typedef struct packed {
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [15:0] base_addr;
  logic        busy;
  logic        done;
  logic        wrapped;
  logic [15:0] words_written;
  logic [7:0]  err_count;

  onchip_stream_writer_if #(.ADDR_W(ADDR_W)) bus ();

  onchip_stream_writer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .flush         (flush),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .wrapped       (wrapped),
    .words_written (words_written),
    .err_count     (err_count)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  wr_t         exp_q[$];
  logic [15:0] m_ptr;
  int          m_lane;
  logic [3:0]  m_be;
  logic [31:0] m_data;
  int          m_words;
  logic        m_wrapped;
  int          cycle         = 0;
  int          last_wr_cycle = -1;
  int          wr_interval   = 0;
  bit          corrupt_en    = 1'b0;
  logic [31:0] ram [0:DEPTH-1];

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter for throughput measurement
  always @(posedge clk) cycle <= cycle + 1;

  // RAM model with 1-cycle read latency and optional lane-1 bit-0 corruption on readback
  always @(posedge clk) begin
    if (bus.mem_chipselect && bus.mem_write) begin
      for (int i = 0; i < 4; i++)
        if (bus.mem_byteenable[i]) ram[bus.mem_address][8*i +: 8] <= bus.mem_writedata[8*i +: 8];
    end
    if (bus.mem_chipselect && !bus.mem_write)
      bus.mem_readdata <= ram[bus.mem_address] ^ (corrupt_en ? 32'h0000_0100 : 32'h0);
  end

  // Scoreboard: every RAM write must match the oldest expected write
  always @(negedge clk) begin
    wr_t e;
    if (bus.mem_chipselect && bus.mem_write) begin
      checkOutput("ready_in_write", 32'(bus.s_ready), 32'd0);
      checkOutput("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("wr_addr", 32'(bus.mem_address), 32'(e.addr));
        checkOutput("wr_be", 32'(bus.mem_byteenable), 32'(e.be));
        checkOutput("wr_data", bus.mem_writedata, e.data);
      end
      if (last_wr_cycle >= 0) wr_interval = cycle - last_wr_cycle;
      last_wr_cycle = cycle;
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, actual, expected, $time);
    end
  endtask

  task automatic pushWrite();
    exp_q.push_back('{addr: m_ptr, be: m_be, data: m_data});
    if (32'(m_ptr) == DEPTH - 1) begin
      m_ptr     = 16'h0000;
      m_wrapped = 1'b1;
    end else begin
      m_ptr = m_ptr + 16'd1;
    end
    m_words++;
    m_lane = 0;
    m_be   = 4'h0;
    m_data = 32'h0;
  endtask

  task automatic startSession(input logic [15:0] base);
    @(negedge clk);
    start     = 1'b1;
    base_addr = base;
    @(posedge clk);
    #1 start = 1'b0;
    m_ptr     = (32'(base) >= DEPTH) ? 16'h0000 : base;
    m_lane    = 0;
    m_be      = 4'h0;
    m_data    = 32'h0;
    m_words   = 0;
    m_wrapped = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit fl);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    while (!bus.s_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) checkOutput("ready_timeout", 32'(bus.s_ready), 32'd1);
    flush = fl;
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    flush       = 1'b0;
    m_data[8*m_lane +: 8] = b;
    m_be[m_lane]          = 1'b1;
    m_lane++;
    if (m_lane == 4 || fl) pushWrite();
  endtask

  task automatic doFlush();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    if (m_lane > 0) pushWrite();
  endtask

  task automatic waitDone(input string tag);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!done && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    @(negedge clk);
    checkOutput({tag, "_done_width"}, 32'(done), 32'd0);
    checkOutput({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_s_ready"}, 32'(bus.s_ready), 32'd0);
    checkOutput({tag, "_cs"}, 32'(bus.mem_chipselect), 32'd0);
    checkOutput({tag, "_write"}, 32'(bus.mem_write), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_wrapped"}, 32'(wrapped), 32'd0);
    checkOutput({tag, "_addr"}, 32'(bus.mem_address), 32'd0);
    checkOutput({tag, "_be"}, 32'(bus.mem_byteenable), 32'd0);
    checkOutput({tag, "_wdata"}, bus.mem_writedata, 32'd0);
    checkOutput({tag, "_words"}, 32'(words_written), 32'd0);
    checkOutput({tag, "_err"}, 32'(err_count), 32'd0);
    checkOutput({tag, "_clken"}, 32'(bus.mem_clken), 32'd1);
  endtask

  // Main stimulus sequence
  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    flush       = 1'b0;
    base_addr   = 16'h0000;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    m_ptr = 16'h0; m_lane = 0; m_be = 4'h0; m_data = 32'h0; m_words = 0; m_wrapped = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetValues("rst");
    reset = 1'b0;

    $display("[TB] single word");
    startSession(16'h0010);
    applyStimulus(8'h11, 1'b0);
    applyStimulus(8'h22, 1'b0);
    applyStimulus(8'h33, 1'b0);
    applyStimulus(8'h44, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("sw_words", 32'(words_written), 32'(m_words));
    doFlush();
    waitDone("sw");

    $display("[TB] partial flush");
    startSession(16'h0020);
    applyStimulus(8'hAA, 1'b0);
    applyStimulus(8'hBB, 1'b0);
    doFlush();
    @(negedge clk);
    checkOutput("pf_write_cycle", 32'(bus.mem_write), 32'd1);
    @(negedge clk);
    checkOutput("pf_done", 32'(done), 32'd1);
    @(negedge clk);
    checkOutput("pf_done_width", 32'(done), 32'd0);
    checkOutput("pf_busy", 32'(busy), 32'd0);
    checkOutput("pf_words", 32'(words_written), 32'(m_words));

    $display("[TB] wrap-around");
    startSession(16'h9FFF);
    for (int i = 0; i < 8; i++) applyStimulus(8'(8'hC0 + i), 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("wrap_flag", 32'(wrapped), 32'(m_wrapped));
    checkOutput("wrap_words", 32'(words_written), 32'(m_words));
    checkOutput("wrap_interval", 32'(wr_interval), 32'(CYCLES_PER_WORD));
    doFlush();
    waitDone("wrap");

    $display("[TB] flush with 4th byte");
    startSession(16'h0100);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h02, 1'b0);
    applyStimulus(8'h03, 1'b0);
    applyStimulus(8'h04, 1'b1);
    waitDone("simul");
    checkOutput("simul_words", 32'(words_written), 32'(m_words));
    checkOutput("simul_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] base clamp and flush in idle");
    startSession(16'hA000);
    applyStimulus(8'h5A, 1'b1);
    waitDone("clamp");
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checkOutput("idle_flush_busy", 32'(busy), 32'd0);
    checkOutput("idle_flush_done", 32'(done), 32'd0);

    $display("[TB] reset mid-session");
    startSession(16'h0200);
    applyStimulus(8'hDE, 1'b0);
    applyStimulus(8'hAD, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkResetValues("midrst");
    reset  = 1'b0;
    m_lane = 0; m_be = 4'h0; m_data = 32'h0;
    startSession(16'h0300);
    for (int i = 0; i < 4; i++) applyStimulus(8'(8'h70 + i), 1'b0);
    doFlush();
    waitDone("after_rst");

`ifdef ONCHIP_WRITER_VERIFY_EN
    $display("[TB] readback verify");
    startSession(16'h0400);
    checkOutput("v_err_cleared", 32'(err_count), 32'd0);
    corrupt_en = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(8'(8'h90 + i), 1'b0);
    repeat (4) @(negedge clk);
    corrupt_en = 1'b0;
    checkOutput("v_err_corrupt", 32'(err_count), 32'd1);
    for (int i = 0; i < 4; i++) applyStimulus(8'(8'hA0 + i), 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("v_err_clean", 32'(err_count), 32'd1);
    checkOutput("v_interval", 32'(wr_interval), 32'(CYCLES_PER_WORD));
    doFlush();
    waitDone("verify");
`endif

    repeat (5) @(negedge clk);
    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
